tm1638_scan_controller: RTL and testbench

TM1638_SCAN_CONTROLLER -- requirements
Module: tm1638_scan_controller

---
 rtl/tm1638_scan_controller_if.sv | 29 ++
 rtl/tm1638_scan_controller.sv | 185 ++++++++++++++++++
 tb/tb_tm1638_scan_controller.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tm1638_scan_controller_if.sv
// Purpose: client-side request/frame bus and display-side scan outputs of the TM1638 scan controller.
// Latency: none; pure signal bundle.
// Backpressure: req_* are level requests held by the client until its gnt_* pulse is seen.
interface tm1638_scan_controller_if #(
    parameter int w_digit = 8
);
    logic                   req_a;
    logic                   req_b;
    logic [8*w_digit-1:0]   frame_a;
    logic [8*w_digit-1:0]   frame_b;
    logic                   gnt_a;
    logic                   gnt_b;
    logic [7:0]             hgfedcba;
    logic [w_digit-1:0]     digit;
    logic                   busy;
    logic                   frame_done;

    // Client / stimulus side: issues requests and frames, observes grants and scan outputs.
    modport master (
        output req_a, req_b, frame_a, frame_b,
        input  gnt_a, gnt_b, hgfedcba, digit, busy, frame_done
    );

    // Controller side.
    modport slave (
        input  req_a, req_b, frame_a, frame_b,
        output gnt_a, gnt_b, hgfedcba, digit, busy, frame_done
    );
endinterface

// File: rtl/tm1638_scan_controller.sv
// Purpose: two-client round-robin frame loader and multiplexed digit scanner (macro TM1638_SCAN_BLANK_EN adds inter-digit blanking).
// Latency: grant 1 cycle after a request seen in IDLE; first digit driven the cycle after the grant.
// Backpressure: requests are held by clients and served only at frame boundaries; scanning never stalls.
module tm1638_scan_controller #(
    parameter int w_digit      = 8,
    parameter int dwell_cycles = 1000,
    parameter int blank_cycles = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    tm1638_scan_controller_if.slave bus
);
    localparam int IW = (w_digit > 1) ? $clog2(w_digit) : 1;
    localparam int DW = (dwell_cycles > 1) ? $clog2(dwell_cycles) : 1;
    localparam logic [IW-1:0]      LAST_IDX   = IW'(w_digit - 1);
    localparam logic [DW-1:0]      DWELL_LAST = DW'(dwell_cycles - 1);
    localparam logic [w_digit-1:0] DIGIT_ONE  = w_digit'(1);
`ifdef TM1638_SCAN_BLANK_EN
    localparam int BW = (blank_cycles > 1) ? $clog2(blank_cycles) : 1;
    localparam logic [BW-1:0]      BLANK_LAST = BW'(blank_cycles - 1);
`endif

    // Both timing parameters are counts of whole cycles; zero would make a phase vanish.
    if (dwell_cycles < 1 || blank_cycles < 1) begin : g_param_check
        $error("tm1638_scan_controller: dwell_cycles and blank_cycles must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_BLANK = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DW-1:0]          dcnt_q, dcnt_d;
`ifdef TM1638_SCAN_BLANK_EN
    logic [BW-1:0]          bcnt_q, bcnt_d;
`endif
    logic [8*w_digit-1:0]   frame_q, frame_d;
    logic                   rr_b_q, rr_b_d;          // 1: client B wins the next tie
    logic                   gnt_a_q, gnt_a_d;
    logic                   gnt_b_q, gnt_b_d;
    logic                   frame_done_q, frame_done_d;
    logic [w_digit-1:0]     digit_q, digit_d;
    logic [7:0]             hgfedcba_q, hgfedcba_d;
    logic                   busy_q, busy_d;

    logic any_req;
    logic win_a;
    logic start_load;
    logic step_done;

    assign any_req = bus.req_a | bus.req_b;
    // A wins unless B is also asking and it is B's turn.
    assign win_a   = bus.req_a & ~(bus.req_b & rr_b_q);

    // Next-state, counters, frame latch and arbitration; outputs are derived from the next state
    // so every output leaves a flop.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dcnt_d       = dcnt_q;
`ifdef TM1638_SCAN_BLANK_EN
        bcnt_d       = bcnt_q;
`endif
        frame_d      = frame_q;
        rr_b_d       = rr_b_q;
        gnt_a_d      = 1'b0;
        gnt_b_d      = 1'b0;
        frame_done_d = 1'b0;
        start_load   = 1'b0;
        step_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                start_load = any_req;
            end
            ST_LOAD: begin
                // The winner holds its frame until it has seen gnt, so it is stable on this edge.
                frame_d = gnt_a_q ? bus.frame_a : bus.frame_b;
                idx_d   = '0;
                dcnt_d  = '0;
                state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (dcnt_q == DWELL_LAST) begin
                    dcnt_d = '0;
`ifdef TM1638_SCAN_BLANK_EN
                    bcnt_d  = '0;
                    state_d = ST_BLANK;
`else
                    step_done = 1'b1;
`endif
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
`ifdef TM1638_SCAN_BLANK_EN
            ST_BLANK: begin
                if (bcnt_q == BLANK_LAST) begin
                    bcnt_d    = '0;
                    step_done = 1'b1;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // End of one digit slot: next digit, or frame boundary where pending requests are served.
        if (step_done) begin
            if (idx_q != LAST_IDX) begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_DRIVE;
            end else begin
                frame_done_d = 1'b1;
                if (any_req) begin
                    start_load = 1'b1;
                end else begin
                    idx_d   = '0;
                    state_d = ST_DRIVE;
                end
            end
        end

        if (start_load) begin
            state_d = ST_LOAD;
            gnt_a_d = win_a;
            gnt_b_d = ~win_a;
            rr_b_d  = win_a;
        end

        busy_d     = (state_d != ST_IDLE);
        digit_d    = (state_d == ST_DRIVE) ? (DIGIT_ONE << idx_d) : '0;
        hgfedcba_d = (state_d == ST_DRIVE) ? frame_d[{idx_d, 3'b000} +: 8] : 8'h00;
    end

    // State and registered outputs; reset parks everything in IDLE with A holding priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            dcnt_q       <= '0;
`ifdef TM1638_SCAN_BLANK_EN
            bcnt_q       <= '0;
`endif
            frame_q      <= '0;
            rr_b_q       <= 1'b0;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            frame_done_q <= 1'b0;
            digit_q      <= '0;
            hgfedcba_q   <= 8'h00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dcnt_q       <= dcnt_d;
`ifdef TM1638_SCAN_BLANK_EN
            bcnt_q       <= bcnt_d;
`endif
            frame_q      <= frame_d;
            rr_b_q       <= rr_b_d;
            gnt_a_q      <= gnt_a_d;
            gnt_b_q      <= gnt_b_d;
            frame_done_q <= frame_done_d;
            digit_q      <= digit_d;
            hgfedcba_q   <= hgfedcba_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.gnt_a      = gnt_a_q;
    assign bus.gnt_b      = gnt_b_q;
    assign bus.frame_done = frame_done_q;
    assign bus.digit      = digit_q;
    assign bus.hgfedcba   = hgfedcba_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_tm1638_scan_controller.sv
// Purpose: scoreboard bench for tm1638_scan_controller with a frame-position reference model.
// Latency: model expects grant one cycle after a request in IDLE, scan starts the cycle after.
// Backpressure: clients hold req until gnt, then release; frames are queued per client.
module tb_tm1638_scan_controller;
    localparam int W  = 4;
    localparam int D  = 4;
    localparam int BC = 2;
`ifdef TM1638_SCAN_BLANK_EN
    localparam int BK = BC;
`else
    localparam int BK = 0;
`endif
    localparam int SLOT = D + BK;
    localparam int P    = W * SLOT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tm1638_scan_controller_if #(.w_digit(W)) bus();

    tm1638_scan_controller #(
        .w_digit     (W),
        .dwell_cycles(D),
        .blank_cycles(BC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [8*W-1:0] exp_a[$];
    logic [8*W-1:0] exp_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Client raises a request with a frame; the expected frame goes to that client's queue.
    task automatic issue(input bit is_b, input logic [8*W-1:0] f);
        if (!is_b) begin
            bus.frame_a = f;
            exp_a.push_back(f);
            bus.req_a = 1'b1;
        end else begin
            bus.frame_b = f;
            exp_b.push_back(f);
            bus.req_b = 1'b1;
        end
    endtask

    task automatic wait_digit(input logic [W-1:0] pat, input int limit, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (bus.digit == pat) found = 1'b1;
        end
        check(name, 64'(found), 64'd1);
    endtask

    task automatic wait_drain(input int limit, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            step();
            if (!bus.req_a && !bus.req_b && exp_a.size() == 0 && exp_b.size() == 0) done = 1'b1;
        end
        check(name, 64'(done), 64'd1);
    endtask

    // Clients drop their request once they have seen their grant.
    initial begin : release_proc
        bit ga, gb;
        forever begin
            @(negedge clk);
            ga = bus.gnt_a;
            gb = bus.gnt_b;
            if (ga || gb) begin
                #2;
                if (ga) bus.req_a = 1'b0;
                if (gb) bus.req_b = 1'b0;
            end
        end
    end

    // Monitor: reference model by position within the frame, compared every cycle.
    initial begin : monitor
        int             mode;      // 0 idle, 1 load, 2 scanning
        int             t;         // cycle number within the current frame
        int             idx;
        bit             pref_a;
        bit             go;
        bit             win_b;
        bit             e_ga, e_gb, e_fd, e_busy;
        logic [W-1:0]   e_dig;
        logic [7:0]     e_seg;
        logic [8*W-1:0] cur;
        mode = 0; t = 0; pref_a = 1'b1; cur = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mode = 0; t = 0; pref_a = 1'b1; cur = '0;
                check("rst_digit", 64'(bus.digit), 64'd0);
                check("rst_seg", 64'(bus.hgfedcba), 64'd0);
                check("rst_busy", 64'(bus.busy), 64'd0);
                check("rst_gnt", 64'({bus.gnt_a, bus.gnt_b}), 64'd0);
                check("rst_fd", 64'(bus.frame_done), 64'd0);
                continue;
            end
            go = 1'b0; e_ga = 1'b0; e_gb = 1'b0; e_fd = 1'b0;
            case (mode)
                0: go = bus.req_a | bus.req_b;
                1: begin mode = 2; t = 0; end
                default: begin
                    t++;
                    if (t == P) begin
                        e_fd = 1'b1;
                        t = 0;
                        go = bus.req_a | bus.req_b;
                    end
                end
            endcase
            if (go) begin
                win_b = bus.req_b && (!bus.req_a || !pref_a);
                mode = 1;
                if (win_b) begin
                    e_gb = 1'b1;
                    check("pop_b_nonempty", 64'(exp_b.size() != 0), 64'd1);
                    if (exp_b.size() != 0) cur = exp_b.pop_front();
                end else begin
                    e_ga = 1'b1;
                    check("pop_a_nonempty", 64'(exp_a.size() != 0), 64'd1);
                    if (exp_a.size() != 0) cur = exp_a.pop_front();
                end
                pref_a = win_b;
            end
            e_busy = (mode != 0);
            e_dig  = '0;
            e_seg  = 8'h00;
            if (mode == 2 && (t % SLOT) < D) begin
                idx   = t / SLOT;
                e_dig = W'(1) << idx;
                e_seg = cur[8*idx +: 8];
            end
            check("digit", 64'(bus.digit), 64'(e_dig));
            check("hgfedcba", 64'(bus.hgfedcba), 64'(e_seg));
            check("busy", 64'(bus.busy), 64'(e_busy));
            check("gnt_a", 64'(bus.gnt_a), 64'(e_ga));
            check("gnt_b", 64'(bus.gnt_b), 64'(e_gb));
            check("frame_done", 64'(bus.frame_done), 64'(e_fd));
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit found;
        int na, nb;
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        bus.frame_a = '0; bus.frame_b = '0;
        #3 rst = 1'b0;
        #1;
        check("reset_digit", 64'(bus.digit), 64'd0);
        check("reset_seg", 64'(bus.hgfedcba), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_fd", 64'(bus.frame_done), 64'd0);
        repeat (3) step();
        rst = 1'b1;
        repeat (6) step();

        // Single client A with a known frame, then repeated rescans with no requests.
        issue(1'b0, 32'h07_66_06_3F);
        repeat (3 * P + 4) step();

        // B requests mid-frame; current frame must finish before B is loaded.
        wait_digit(4'b0010, 2 * P, "wait_digit1_b");
        #1;
        issue(1'b1, 32'($urandom));
        wait_drain(3 * P, "drain_b");
        repeat (P) step();

        // Both clients keep requesting: grants must alternate at frame boundaries.
        na = 0; nb = 0;
        for (int c = 0; c < 12 * P && (na < 3 || nb < 3); c++) begin
            step();
            if (!bus.req_a && na < 3) begin issue(1'b0, 32'($urandom)); na++; end
            if (!bus.req_b && nb < 3) begin issue(1'b1, 32'($urandom)); nb++; end
        end
        wait_drain(4 * P, "drain_alt");
        repeat (P / 2) step();

        // Asynchronous reset in the middle of digit 2.
        wait_digit(4'b0100, 2 * P, "wait_digit2_rst");
        #1 rst = 1'b0;
        #1;
        check("arst_digit", 64'(bus.digit), 64'd0);
        check("arst_seg", 64'(bus.hgfedcba), 64'd0);
        check("arst_busy", 64'(bus.busy), 64'd0);
        step();
        rst = 1'b1;
        repeat (10) step();
        check("post_rst_idle_busy", 64'(bus.busy), 64'd0);
        issue(1'b0, 32'($urandom));
        issue(1'b1, 32'($urandom));
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge clk);
            if (bus.gnt_a || bus.gnt_b) found = 1'b1;
        end
        check("post_rst_gnt_seen", 64'(found), 64'd1);
        check("post_rst_winner_a", 64'(bus.gnt_a), 64'd1);
        #1;
        wait_drain(4 * P, "drain_post_rst");

        // Random request traffic.
        for (int c = 0; c < 400; c++) begin
            step();
            if (!bus.req_a && $urandom_range(0, 39) == 0) issue(1'b0, 32'($urandom));
            if (!bus.req_b && $urandom_range(0, 39) == 0) issue(1'b1, 32'($urandom));
        end
        wait_drain(6 * P, "drain_random");
        repeat (P + 2) step();
        check("queue_a_empty", 64'(exp_a.size()), 64'd0);
        check("queue_b_empty", 64'(exp_b.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
